// File: rtl/mont_arbiter.sv
// -----------------------------------------------------------------------------
// mont_arbiter
//
// Shares one Montgomery multiplier core between N requesters. One operation is
// in flight at a time: a requester is picked round-robin in IDLE, its operands
// are latched and presented to the core (ISSUE), the arbiter then waits for the
// core result (WAIT) and returns it to the same requester (RESP).
//
// Parameters
//   N   number of requesters (N >= 2)
//   DW  operand / result width
//
// Ports
//   clk                        rising-edge clock
//   rst                        asynchronous, active-low reset
//   req_valid / req_ready [N]  per-requester operand handshake
//   req_a / req_b [N][DW]      per-requester operands
//   rsp_valid / rsp_ready [N]  per-requester result handshake
//   rsp_data [DW]              shared result bus, qualified by rsp_valid
//   core_i_valid/core_i_ready  operand handshake towards the core
//   core_a / core_b [DW]       operands towards the core
//   core_o_valid/core_o_ready  result handshake from the core
//   core_o_data [DW]           core result
//   busy                       high whenever the FSM is not in IDLE
//   grant_id [clog2(N)]        index of the current / last granted requester
// -----------------------------------------------------------------------------
module mont_arbiter #(
  parameter  int N  = 4,
  parameter  int DW = 256,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N-1:0][DW-1:0] req_a,
  input  logic [N-1:0][DW-1:0] req_b,
  output logic [N-1:0]         rsp_valid,
  input  logic [N-1:0]         rsp_ready,
  output logic [DW-1:0]        rsp_data,
  output logic                 core_i_valid,
  input  logic                 core_i_ready,
  output logic [DW-1:0]        core_a,
  output logic [DW-1:0]        core_b,
  input  logic                 core_o_valid,
  output logic                 core_o_ready,
  input  logic [DW-1:0]        core_o_data,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [IW:0]   N_EXT = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  state_t          state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   grant_reg;
  logic [DW-1:0]   opa_reg;
  logic [DW-1:0]   opb_reg;
  logic [DW-1:0]   res_reg;
  logic            busy_reg;
  logic            core_i_valid_reg;
  logic            core_o_ready_reg;
  logic [N-1:0]    rsp_valid_reg;

  // ---------------------------------------------------------------------------
  // Round-robin selection.
  // The request vector is rotated so that bit 0 corresponds to ptr_reg; the
  // lowest set bit of the rotated vector is then the first requester at or
  // after ptr_reg (with wrap-around). Doubling the vector avoids a modulo in
  // the rotate.
  // ---------------------------------------------------------------------------
  logic [2*N-1:0]  dbl_valid;
  logic [N-1:0]    rot_valid;
  logic            found;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;
  logic [IW-1:0]   sel_idx;

  assign dbl_valid = {req_valid, req_valid};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot_valid[gi] = dbl_valid[{1'b0, ptr_reg} + (IW+1)'(gi)];
    end
  endgenerate

  // Scanning downward lets the lowest rotated index win.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
  end

  assign sum     = {1'b0, ptr_reg} + {1'b0, off};
  assign sel_idx = (sum >= N_EXT) ? IW'(sum - N_EXT) : IW'(sum);

  // req_ready is combinational so the grant happens in the same IDLE cycle.
  // It is also gated by rst so nothing is accepted while reset is held.
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign req_ready[gi] = rst && (state_reg == IDLE) && found &&
                             (sel_idx == IW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      grant_reg        <= '0;
      opa_reg          <= '0;
      opb_reg          <= '0;
      res_reg          <= '0;
      busy_reg         <= 1'b0;
      core_i_valid_reg <= 1'b0;
      core_o_ready_reg <= 1'b0;
      rsp_valid_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            opa_reg          <= req_a[sel_idx];
            opb_reg          <= req_b[sel_idx];
            grant_reg        <= sel_idx;
            busy_reg         <= 1'b1;
            core_i_valid_reg <= 1'b1;
            state_reg        <= ISSUE;
          end
        end

        ISSUE: begin
          if (core_i_ready) begin
            core_i_valid_reg <= 1'b0;
            core_o_ready_reg <= 1'b1;
            state_reg        <= WAIT;
          end
        end

        WAIT: begin
          if (core_o_valid) begin
            res_reg          <= core_o_data;
            core_o_ready_reg <= 1'b0;
            rsp_valid_reg    <= N'(1) << grant_reg;
            state_reg        <= RESP;
          end
        end

        RESP: begin
          // Only the granted requester's rsp_ready can complete the response.
          if (rsp_ready[grant_reg]) begin
            rsp_valid_reg <= '0;
            busy_reg      <= 1'b0;
            ptr_reg       <= (grant_reg == LAST) ? '0 : grant_reg + 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign grant_id     = grant_reg;
  assign core_i_valid = core_i_valid_reg;
  assign core_o_ready = core_o_ready_reg;
  assign core_a       = opa_reg;
  assign core_b       = opb_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = res_reg;

endmodule

// File: doc/mont_arbiter.md
MONT_ARBITER -- requirements
Module: mont_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters sharing one Montgomery multiplier core, N >= 2.
REQ-002 SHALL have parameter DW, default 256: operand/result width.
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  [N]  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  [N]  per-requester operand accept.
REQ-007 SHALL have port req_a / req_b  input  [N][DW]  per-requester operands.
REQ-008 SHALL have port rsp_valid  output  [N]  per-requester result valid, at most one bit high.
REQ-009 SHALL have port rsp_ready  input  [N]  per-requester result accept.
REQ-010 SHALL have port rsp_data  output  DW  shared result bus, qualified by rsp_valid.
REQ-011 SHALL have port core_i_valid / core_i_ready  output / input  1  core operand handshake.
REQ-012 SHALL have port core_a / core_b  output  DW  core operands.
REQ-013 SHALL have port core_o_valid / core_o_ready  input / output  1  core result handshake.
REQ-014 SHALL have port core_o_data  input  DW  core result.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port grant_id  output  clog2(N)  index of current/last granted requester.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one operation outstanding at a time.
REQ-018 IDLE: SHALL select the first requester with req_valid high, searching from ptr upward with wrap N-1 -> 0; SHALL drive req_ready high for that requester only, in the same cycle, combinationally.
REQ-019 On the IDLE handshake SHALL latch req_a/req_b and the index into grant_id, then enter ISSUE; no request in IDLE -> stay in IDLE.
REQ-020 req_ready SHALL be all-zero in ISSUE, WAIT and RESP.
REQ-021 ISSUE: SHALL drive core_i_valid=1 with the latched operands on core_a/core_b, held stable until core_i_ready; on the handshake SHALL enter WAIT.
REQ-022 WAIT: SHALL drive core_o_ready=1; on core_o_valid SHALL latch core_o_data and enter RESP.
REQ-023 core_o_ready SHALL be 0 outside WAIT; core_i_valid SHALL be 0 outside ISSUE.
REQ-024 RESP: SHALL drive rsp_valid[grant_id]=1 and rsp_data=latched result, both stable until rsp_ready[grant_id]; rsp_ready of other requesters SHALL be ignored.
REQ-025 On the RESP handshake SHALL set ptr=(grant_id+1) mod N and enter IDLE.
REQ-026 Minimum latency: request handshake at cycle t -> core_i_valid at t+1; core_o_valid at cycle u -> rsp_valid at u+1.
REQ-027 Fairness: a continuously asserted request SHALL be granted within N grants.
REQ-028 req_valid changes outside IDLE SHALL have no effect on state or outputs.

Reset
REQ-029 On rst low, asynchronously: state=IDLE, ptr=0, grant_id=0, busy=0, all req_ready/rsp_valid=0, core_i_valid=0, core_o_ready=0, latched operands/result=0.
REQ-030 Reset mid-operation SHALL abandon the operation; no rsp_valid SHALL be produced for it after release.
REQ-031 First arbitration after reset SHALL search from index 0.

Verification
REQ-032 Single request: N=4, req_valid[2], a=3, b=5, core returns 0x0F after 10 cycles -> rsp_valid[2] one cycle after core_o_valid, rsp_data=0x0F, grant_id=2.
REQ-033 Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; wrap from 3 to 0.
REQ-034 Backpressure: core_i_ready low 5 cycles, then rsp_ready low 3 cycles -> core_a/core_b and rsp_data stable, exactly one core handshake, one response.
REQ-035 Blocking: second request arriving during WAIT -> req_ready all 0 until RESP handshake, then granted in next IDLE cycle.
REQ-036 Reset in WAIT: rst low 2 cycles -> all outputs at reset values, no rsp_valid afterwards, next grant searches from 0.
